// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered RV32I decode/control stage with a valid/ready
// handshake, stall, flush, illegal-encoding detection and a saturating count of
// decoded instructions.
// Optional feature: define CTRL_MEXT_EN to decode the M extension (funct7=0x01).
module ctrl_decode_stage #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic [31:0]      i_instr,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_out_vld,
  input  logic             i_out_rdy,
  output logic [PC_W-1:0]  o_pc,
  output logic [4:0]       o_rs1_addr,
  output logic [4:0]       o_rs2_addr,
  output logic [4:0]       o_rd_addr,
  output logic             o_opa_sel,
  output logic             o_opb_sel,
  output logic [4:0]       o_alu_op,
  output logic [1:0]       o_wb_sel,
  output logic [2:0]       o_ld_sel,
  output logic [1:0]       o_st_sel,
  output logic [2:0]       o_br_type,
  output logic             o_jump,
  output logic             o_mem_wren,
  output logic             o_rd_wren,
  output logic             o_insn_vld,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_decode_cnt
);

  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpFence  = 7'h0f;

  localparam logic [4:0] AluAdd   = 5'd0;
  localparam logic [4:0] AluSub   = 5'd1;
  localparam logic [4:0] AluSra   = 5'd9;
  localparam logic [4:0] AluPassB = 5'd10;

  localparam logic [1:0] WbPc4  = 2'd0;
  localparam logic [1:0] WbAlu  = 2'd1;
  localparam logic [1:0] WbLoad = 2'd2;
  localparam logic [1:0] WbNone = 2'd3;
  localparam logic [2:0] LdNone = 3'd5;
  localparam logic [1:0] StNone = 2'd3;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd     = i_instr[11:7];

  // Shared funct3 -> ALU op map for register and immediate ALU forms.
  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_of_f3 = 5'd0;  // ADD
      3'd1:    alu_of_f3 = 5'd7;  // SLL
      3'd2:    alu_of_f3 = 5'd2;  // SLT
      3'd3:    alu_of_f3 = 5'd3;  // SLTU
      3'd4:    alu_of_f3 = 5'd4;  // XOR
      3'd5:    alu_of_f3 = 5'd8;  // SRL
      3'd6:    alu_of_f3 = 5'd5;  // OR
      default: alu_of_f3 = 5'd6;  // AND
    endcase
  endfunction

  logic       d_opa, d_opb, d_jump, d_mem_wren, d_writes_rd, d_illegal, d_rd_wren;
  logic [4:0] d_alu;
  logic [1:0] d_wb, d_st;
  logic [2:0] d_ld, d_br;

  // Combinational decode of the incoming word; only ever sampled into registers.
  always_comb begin
    d_opa       = 1'b0;
    d_opb       = 1'b0;
    d_alu       = AluAdd;
    d_wb        = WbNone;
    d_ld        = LdNone;
    d_st        = StNone;
    d_br        = 3'd0;
    d_jump      = 1'b0;
    d_mem_wren  = 1'b0;
    d_writes_rd = 1'b0;
    d_illegal   = 1'b0;
    case (opcode)
      OpReg: begin
        d_writes_rd = 1'b1;
        d_wb        = WbAlu;
        if (funct7 == 7'h00) begin
          d_alu = alu_of_f3(funct3);
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          d_alu = AluSub;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          d_alu = AluSra;
`ifdef CTRL_MEXT_EN
        end else if (funct7 == 7'h01) begin
          d_alu = {2'b10, funct3};
`endif
        end else begin
          d_illegal = 1'b1;
        end
      end
      OpImm: begin
        d_writes_rd = 1'b1;
        d_wb        = WbAlu;
        d_opb       = 1'b1;
        d_alu       = alu_of_f3(funct3);
        if (funct3 == 3'd1 && funct7 != 7'h00) d_illegal = 1'b1;
        if (funct3 == 3'd5) begin
          if (funct7 == 7'h20)      d_alu = AluSra;
          else if (funct7 != 7'h00) d_illegal = 1'b1;
        end
      end
      OpLui: begin
        d_writes_rd = 1'b1;
        d_wb        = WbAlu;
        d_opb       = 1'b1;
        d_alu       = AluPassB;
      end
      OpAuipc: begin
        d_writes_rd = 1'b1;
        d_wb        = WbAlu;
        d_opa       = 1'b1;
        d_opb       = 1'b1;
      end
      OpJal: begin
        d_writes_rd = 1'b1;
        d_wb        = WbPc4;
        d_opa       = 1'b1;
        d_opb       = 1'b1;
        d_jump      = 1'b1;
      end
      OpJalr: begin
        d_writes_rd = 1'b1;
        d_wb        = WbPc4;
        d_opb       = 1'b1;
        d_jump      = 1'b1;
        d_illegal   = (funct3 != 3'd0);
      end
      OpStore: begin
        d_opb      = 1'b1;
        d_mem_wren = 1'b1;
        d_st       = funct3[1:0];
        d_illegal  = (funct3 > 3'd2);
      end
      OpBranch: begin
        d_opa = 1'b1;
        d_opb = 1'b1;
        case (funct3)
          3'd0:    d_br = 3'd1;
          3'd1:    d_br = 3'd2;
          3'd4:    d_br = 3'd3;
          3'd5:    d_br = 3'd4;
          3'd6:    d_br = 3'd5;
          3'd7:    d_br = 3'd6;
          default: d_illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        d_writes_rd = 1'b1;
        d_wb        = WbLoad;
        d_opb       = 1'b1;
        case (funct3)
          3'd0:    d_ld = 3'd0;
          3'd1:    d_ld = 3'd1;
          3'd2:    d_ld = 3'd2;
          3'd4:    d_ld = 3'd3;
          3'd5:    d_ld = 3'd4;
          default: d_illegal = 1'b1;
        endcase
      end
      // FENCE is a no-op for an in-order core with no caches; SYSTEM falls to
      // the illegal path so ECALL/EBREAK reach the trap logic.
      OpFence: d_illegal = (funct3 != 3'd0);
      default: d_illegal = 1'b1;
    endcase
    // Illegal words carry a neutral control bundle so nothing downstream acts.
    if (d_illegal) begin
      d_opa       = 1'b0;
      d_opb       = 1'b0;
      d_alu       = AluAdd;
      d_wb        = WbNone;
      d_ld        = LdNone;
      d_st        = StNone;
      d_br        = 3'd0;
      d_jump      = 1'b0;
      d_mem_wren  = 1'b0;
      d_writes_rd = 1'b0;
    end
    d_rd_wren = d_writes_rd & (rd != 5'd0);
  end

  logic             out_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, retire;

  assign o_in_rdy  = ~out_vld_q | i_out_rdy;
  assign accept    = i_in_vld & o_in_rdy & ~i_flush;
  assign retire    = out_vld_q & i_out_rdy;
  assign o_out_vld = out_vld_q;
  assign o_decode_cnt = cnt_q;

  // Valid bit: flush wins, then accept, then retire.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       out_vld_q <= 1'b0;
    else if (i_flush)  out_vld_q <= 1'b0;
    else if (accept)   out_vld_q <= 1'b1;
    else if (retire)   out_vld_q <= 1'b0;
  end

  // Payload register: loads only on accept, so a stall holds it bit-stable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc       <= '0;
      o_rs1_addr <= 5'd0;
      o_rs2_addr <= 5'd0;
      o_rd_addr  <= 5'd0;
      o_opa_sel  <= 1'b0;
      o_opb_sel  <= 1'b0;
      o_alu_op   <= AluAdd;
      o_wb_sel   <= WbNone;
      o_ld_sel   <= LdNone;
      o_st_sel   <= StNone;
      o_br_type  <= 3'd0;
      o_jump     <= 1'b0;
      o_mem_wren <= 1'b0;
      o_rd_wren  <= 1'b0;
      o_insn_vld <= 1'b0;
      o_illegal  <= 1'b0;
    end else if (accept) begin
      o_pc       <= i_pc;
      o_rs1_addr <= i_instr[19:15];
      o_rs2_addr <= i_instr[24:20];
      o_rd_addr  <= rd;
      o_opa_sel  <= d_opa;
      o_opb_sel  <= d_opb;
      o_alu_op   <= d_alu;
      o_wb_sel   <= d_wb;
      o_ld_sel   <= d_ld;
      o_st_sel   <= d_st;
      o_br_type  <= d_br;
      o_jump     <= d_jump;
      o_mem_wren <= d_mem_wren;
      o_rd_wren  <= d_rd_wren;
      o_insn_vld <= ~d_illegal;
      o_illegal  <= d_illegal;
    end
  end

  // Saturating count of legal instructions handed to execute.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                  cnt_q <= '0;
    else if (retire && o_insn_vld && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule
